mul: RTL and testbench
======================

# mul

Iterative RV32M multiplier for the execute stage. It computes MUL, MULH, MULHSU and MULHU with one radix-2 shift-add step per cycle, and stalls the pipeline through `hold_o` until the 64-bit product is ready. It sits beside the divider and uses the same start/busy/valid hold handshake, so execute can treat both units the same way.

## Interface
Parameters:
- `Environment`, default `ASIC`: target environment (`environment_e`). No behavioural effect in this block.
- `RV32`, default `RV32I`: selects the implementation. With `RV32M` the multiplier is built. Otherwise every output is tied to 0.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `first_operand_i`  in  32: rs1 value.
- `second_operand_i`  in  32: rs2 value.
- `instruction_operation_i`  in  `iType_e`: current execute operation.
- `hold_o`  out  1: stall request to the pipeline.
- `mul_result_o`  out  32: product[31:0].
- `mulh_result_o`  out  32: product[63:32], signed×signed.
- `mulhsu_result_o`  out  32: product[63:32], signed rs1 × unsigned rs2.
- `mulhu_result_o`  out  32: product[63:32], unsigned×unsigned.

## Operation
- MUL group = {MUL, MULH, MULHSU, MULHU}.
- Start condition: `start = op in group && !busy && !valid`.
- Stall: `hold_o = start | busy`.
- At start:
  - Latch `op_q`.
  - Take magnitudes: `a_mag = (a_sgn && a[31]) ? -a : a`, same rule for `b_mag`.
    - MUL and MULH: `a_sgn = b_sgn = 1`.
    - MULHSU: `a_sgn = 1`, `b_sgn = 0`.
    - MULHU: both 0.
  - Set `neg = (a_sgn&a[31]) ^ (b_sgn&b[31])`.
  - Set `{hi,lo} = {32'b0, b_mag}`, `mcand = a_mag`.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned; no special case.
- Zero shortcut: if either operand is 0 at start, the product register gets 0, `valid` is set, and the state stays M_IDLE.
- State machine `mul_states_e`:
  - M_IDLE: on start, go to M_CALC with counter i=0, unless the zero shortcut applies.
  - M_CALC: `sum[32:0] = {1'b0,hi} + (lo[0] ? mcand : 0)`, then `{hi,lo} <= {sum, lo} >> 1`, and i++. At i==31, go to M_SIGN.
  - M_SIGN: if `neg`, the product becomes its 64-bit two's complement. Clear `busy`, set `valid`, go to M_IDLE.
- Result outputs are driven directly from the product register. All four are driven at all times; only the one matching `op_q` is architecturally meaningful. MUL low word is the same for any signedness.
- Valid hold: `valid` stays set while the op remains equal to `op_q`. This blocks a restart and keeps the result stable.
- Op leaves the group: `valid` and `busy` clear and the state goes to M_IDLE, aborting any operation in flight.
- Op changes to a different group member while busy or valid: abort the same way. The next cycle issues a fresh start.
- Operands must be stable while `hold_o` = 1. This is not checked.
- Back-to-back identical MUL-group ops with no intervening non-group op are not restarted. The decoder and pipeline guarantee a bubble between them.

## Timing
- Reset values: state M_IDLE, `busy` = 0, `valid` = 0, product 0. Therefore every result output is 0 and `hold_o` is 0 while the op is outside the group.
- Normal latency: `hold_o` is high for 34 cycles (start cycle, 32 M_CALC cycles, 1 M_SIGN cycle). Results are valid in the first cycle `hold_o` is low.
- Zero shortcut: `hold_o` is high for 1 cycle. The result is 0 in the next cycle.
- Reset mid-operation takes priority: it returns everything to reset values on the next edge.
- Abort and start never coincide, because abort forces `busy` = `valid` = 0 and start is evaluated in the following cycle.
- Non-RV32M build: `hold_o` = 0 and all results are 0 permanently.

## Structure
- Add `mul_states_e` {M_IDLE, M_CALC, M_SIGN} to `RS5_pkg`, next to `div_states_e`.
- `iType_e` must contain MUL, MULH, MULHSU and MULHU.
- No sub-module is needed: one `always_comb` for the step adder and one `always_ff` for the FSM.
- Use a `generate if (RV32 == RV32M)` split, the same as the divider.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `hold_o` high 34 cycles, then `mul_result_o` = 0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → `mulh_result_o` = 0x40000000, `mul_result_o` = 0x00000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → `mulhsu_result_o` = 0xFFFFFFFF, low word 0x00000001.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → `mulhu_result_o` = 0xFFFFFFFE, low word 0x00000001.
- Zero shortcut: MUL 0 × 0x00001234 → `hold_o` high exactly 1 cycle, `mul_result_o` = 0.
- Abort and restart:
  - Switch the op to ADD at M_CALC cycle 10 → `hold_o` = 0 next cycle.
  - Reissue MUL 5×6 → full 34-cycle hold, result 30.
  - Assert `reset` mid-M_CALC → all outputs 0 on the next edge.

Source files
------------

// File: rtl/RS5_pkg.sv
// -----------------------------------------------------------------------------
// RS5_pkg
// Shared types for the RS5 core execute stage: build environment, ISA
// selection, decoded instruction operations and the multi-cycle unit
// state machines (divider and multiplier).
// No ports; imported by the execute-stage units.
// -----------------------------------------------------------------------------
package RS5_pkg;

  typedef enum logic [0:0] {
    ASIC,
    FPGA
  } environment_e;

  typedef enum logic [1:0] {
    RV32I,
    RV32E,
    RV32M,
    RV32ZMMUL
  } arch_e;

  typedef enum logic [5:0] {
    NOP,
    LUI,
    ADD,
    SUB,
    SLTU,
    SLT,
    XOR,
    OR,
    AND,
    SLL,
    SRL,
    SRA,
    BEQ,
    BNE,
    BLT,
    BLTU,
    BGE,
    BGEU,
    JAL,
    JALR,
    LB,
    LBU,
    LH,
    LHU,
    LW,
    SB,
    SH,
    SW,
    MUL,
    MULH,
    MULHSU,
    MULHU,
    DIV,
    DIVU,
    REM,
    REMU
  } iType_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_CALC,
    D_SIGN
  } div_states_e;

  typedef enum logic [1:0] {
    M_IDLE,
    M_CALC,
    M_SIGN
  } mul_states_e;

  // True for the four operations handled by the multiplier.
  function automatic logic is_mul_op(input iType_e op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == MULHU);
  endfunction

endpackage

// File: rtl/mul.sv
// -----------------------------------------------------------------------------
// mul
// Iterative RV32M multiplier (MUL, MULH, MULHSU, MULHU). One radix-2
// shift-add step per cycle on operand magnitudes, followed by a sign fix-up.
// The pipeline is stalled through hold_o until the 64-bit product is ready.
// Shares the start/busy/valid hold handshake with the divider.
//
// Ports:
//   clk                     in   clock
//   reset                   in   synchronous, active-high reset
//   first_operand_i  [31:0] in   rs1
//   second_operand_i [31:0] in   rs2
//   instruction_operation_i in   current execute operation (iType_e)
//   hold_o                  out  stall request
//   mul_result_o     [31:0] out  product[31:0]
//   mulh_result_o    [31:0] out  product[63:32], signed x signed
//   mulhsu_result_o  [31:0] out  product[63:32], signed x unsigned
//   mulhu_result_o   [31:0] out  product[63:32], unsigned x unsigned
// -----------------------------------------------------------------------------
module mul
  import RS5_pkg::*;
#(
  parameter environment_e Environment = ASIC,
  parameter arch_e        RV32        = RV32I
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] first_operand_i,
  input  logic [31:0] second_operand_i,
  input  iType_e      instruction_operation_i,
  output logic        hold_o,
  output logic [31:0] mul_result_o,
  output logic [31:0] mulh_result_o,
  output logic [31:0] mulhsu_result_o,
  output logic [31:0] mulhu_result_o
);

  // The environment does not change this block's behaviour.
  logic w_unused_env;
  assign w_unused_env = (Environment == FPGA);

  generate
    if (RV32 == RV32M) begin : gen_mul

      mul_states_e r_state;
      logic        r_busy;
      logic        r_valid;
      logic        r_neg;
      iType_e      r_op;
      logic [31:0] r_mcand;
      logic [31:0] r_hi;
      logic [31:0] r_lo;
      logic [4:0]  r_cnt;

      logic        w_in_group;
      logic        w_start;
      logic        w_abort;
      logic        w_a_sgn;
      logic        w_b_sgn;
      logic        w_a_neg;
      logic        w_b_neg;
      logic [31:0] w_a_mag;
      logic [31:0] w_b_mag;
      logic [32:0] w_sum;
      logic [63:0] w_prod_neg;

      assign w_in_group = is_mul_op(instruction_operation_i);
      assign w_start    = w_in_group && !r_busy && !r_valid;

      // Leaving the group, or switching to another group member while a
      // result is pending or in flight, drops everything back to idle; the
      // new op then starts on the following cycle.
      assign w_abort = !w_in_group ||
                       ((r_busy || r_valid) && (instruction_operation_i != r_op));

      assign w_a_sgn = (instruction_operation_i != MULHU);
      assign w_b_sgn = (instruction_operation_i == MUL) ||
                       (instruction_operation_i == MULH);
      assign w_a_neg = w_a_sgn && first_operand_i[31];
      assign w_b_neg = w_b_sgn && second_operand_i[31];

      // 0x80000000 negates to itself, which as an unsigned magnitude is the
      // correct value, so no special case is needed.
      assign w_a_mag = w_a_neg ? (~first_operand_i + 32'd1) : first_operand_i;
      assign w_b_mag = w_b_neg ? (~second_operand_i + 32'd1) : second_operand_i;

      // Step adder: the carry out becomes the new top bit after the shift.
      always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        w_sum      = '0;
        w_prod_neg = '0;
        w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : 33'd0);
        w_prod_neg = ~{r_hi, r_lo} + 64'd1;
      end

      always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
          r_state <= M_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_neg   <= 1'b0;
          r_op    <= NOP;
          r_mcand <= '0;
          r_hi    <= '0;
          r_lo    <= '0;
          r_cnt   <= '0;
        end else if (w_abort) begin
          r_state <= M_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end else begin
          case (r_state)
            M_IDLE: begin
              if (w_start) begin
                r_op  <= instruction_operation_i;
                r_neg <= w_a_neg ^ w_b_neg;
                if ((first_operand_i == '0) || (second_operand_i == '0)) begin
                  r_hi    <= '0;
                  r_lo    <= '0;
                  r_valid <= 1'b1;
                end else begin
                  r_hi    <= '0;
                  r_lo    <= w_b_mag;
                  r_mcand <= w_a_mag;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= M_CALC;
                end
              end
            end

            M_CALC: begin
              // {hi,lo} <= {sum,lo} >> 1
              r_hi  <= w_sum[32:1];
              r_lo  <= {w_sum[0], r_lo[31:1]};
              r_cnt <= r_cnt + 5'd1;
              if (r_cnt == 5'd31) begin
                r_state <= M_SIGN;
              end
            end

            M_SIGN: begin
              if (r_neg) begin
                {r_hi, r_lo} <= w_prod_neg;
              end
              r_busy  <= 1'b0;
              r_valid <= 1'b1;
              r_state <= M_IDLE;
            end

            default: r_state <= M_IDLE;
          endcase
        end
      end

      assign hold_o          = w_start || r_busy;
      assign mul_result_o    = r_lo;
      assign mulh_result_o   = r_hi;
      assign mulhsu_result_o = r_hi;
      assign mulhu_result_o  = r_hi;

    end else begin : gen_no_mul

      logic w_unused_inputs;
      assign w_unused_inputs = ^{clk, reset, first_operand_i, second_operand_i,
                                 instruction_operation_i};

      assign hold_o          = 1'b0;
      assign mul_result_o    = '0;
      assign mulh_result_o   = '0;
      assign mulhsu_result_o = '0;
      assign mulhu_result_o  = '0;

    end
  endgenerate

endmodule

// File: tb/tb_mul.sv
// -----------------------------------------------------------------------------
// tb_mul
// Directed bench for the iterative multiplier: a vector table of operations
// with hand-computed products and stall lengths, plus sequences for abort,
// restart, reset mid-operation and the non-RV32M build.
// -----------------------------------------------------------------------------
module tb_mul;
  import RS5_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  iType_e      op;

  logic        hold;
  logic [31:0] res_mul, res_mulh, res_mulhsu, res_mulhu;
  logic        base_hold;
  logic [31:0] base_mul, base_mulh, base_mulhsu, base_mulhu;

  int n_checks = 0;
  int n_fail   = 0;

  mul #(.Environment(ASIC), .RV32(RV32M)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .first_operand_i         (a),
    .second_operand_i        (b),
    .instruction_operation_i (op),
    .hold_o                  (hold),
    .mul_result_o            (res_mul),
    .mulh_result_o           (res_mulh),
    .mulhsu_result_o         (res_mulhsu),
    .mulhu_result_o          (res_mulhu)
  );

  mul #(.Environment(ASIC), .RV32(RV32I)) dut_base (
    .clk                     (clk),
    .reset                   (reset),
    .first_operand_i         (a),
    .second_operand_i        (b),
    .instruction_operation_i (op),
    .hold_o                  (base_hold),
    .mul_result_o            (base_mul),
    .mulh_result_o           (base_mulh),
    .mulhsu_result_o         (base_mulhsu),
    .mulhu_result_o          (base_mulhu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    iType_e      op;
    logic [31:0] a;
    logic [31:0] b;
    int          hold_cycles;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hi_for(input iType_e o);
    case (o)
      MULHSU:  return res_mulhsu;
      MULHU:   return res_mulhu;
      default: return res_mulh;
    endcase
  endfunction

  // Called at a falling edge. Drives one op, counts stall cycles, checks the
  // product, checks it stays put while the op is held, then inserts a bubble.
  task automatic run_op(input string tag, input vec_t v);
    int cnt;
    op = v.op;
    a  = v.a;
    b  = v.b;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (!hold) break;
      cnt++;
      @(negedge clk);
    end
    check({tag, " hold cycles"}, cnt, v.hold_cycles);
    check({tag, " lo"}, res_mul, v.exp_lo);
    check({tag, " hi"}, hi_for(v.op), v.exp_hi);
    @(negedge clk);
    #1;
    check({tag, " hold stays low"}, {31'd0, hold}, 32'd0);
    check({tag, " lo stable"}, res_mul, v.exp_lo);
    op = ADD;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{MUL,    32'h00000007, 32'hFFFFFFFD, 34, 32'hFFFFFFEB, 32'hFFFFFFFF};
    vecs[1]  = '{MUL,    32'h00000000, 32'h00001234,  1, 32'h00000000, 32'h00000000};
    vecs[2]  = '{MULH,   32'h80000000, 32'h80000000, 34, 32'h00000000, 32'h40000000};
    vecs[3]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h00000001, 32'hFFFFFFFF};
    vecs[4]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h00000001, 32'hFFFFFFFE};
    vecs[5]  = '{MULH,   32'h12345678, 32'h00000010, 34, 32'h23456780, 32'h00000001};
    vecs[6]  = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h00000001, 32'h00000000};
    vecs[7]  = '{MULHU,  32'h80000000, 32'h00000002, 34, 32'h00000000, 32'h00000001};
    vecs[8]  = '{MULHSU, 32'h80000000, 32'h00000002, 34, 32'h00000000, 32'hFFFFFFFF};
    vecs[9]  = '{MULH,   32'hFFFFFFFF, 32'h00000000,  1, 32'h00000000, 32'h00000000};
    vecs[10] = '{MUL,    32'h00000005, 32'h00000006, 34, 32'h0000001E, 32'h00000000};

    reset = 1'b1;
    op    = ADD;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset hold", {31'd0, hold}, 32'd0);
    check("reset mul", res_mul, 32'd0);
    check("reset mulh", res_mulh, 32'd0);
    check("reset mulhsu", res_mulhsu, 32'd0);
    check("reset mulhu", res_mulhu, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Abort at M_CALC step 10, then a fresh full-length restart.
    op = MUL;
    a  = 32'd5;
    b  = 32'd6;
    repeat (11) @(negedge clk);
    #1;
    check("abort busy before", {31'd0, hold}, 32'd1);
    op = ADD;
    @(negedge clk);
    #1;
    check("abort hold low", {31'd0, hold}, 32'd0);
    @(negedge clk);
    run_op("restart", vecs[10]);

    // Reset in the middle of M_CALC; the non-RV32M build stays silent.
    op = MUL;
    a  = 32'h00000007;
    b  = 32'hFFFFFFFD;
    repeat (6) @(negedge clk);
    #1;
    check("mid-calc hold", {31'd0, hold}, 32'd1);
    check("base hold", {31'd0, base_hold}, 32'd0);
    check("base mul", base_mul, 32'd0);
    check("base hi", base_mulh | base_mulhsu | base_mulhu, 32'd0);
    reset = 1'b1;
    op    = ADD;
    @(negedge clk);
    #1;
    check("mid reset hold", {31'd0, hold}, 32'd0);
    check("mid reset mul", res_mul, 32'd0);
    check("mid reset mulh", res_mulh, 32'd0);
    check("mid reset mulhu", res_mulhu, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // After reset the unit must run a normal operation again.
    run_op("post reset", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
